// File: rtl/btb_next_pc.sv
// Next-PC generation stage: a direct-mapped BTB with 2-bit direction counters
// picks between the EX redirect, the predicted target and PC+4 each cycle.
// EX-resolved branches train the table; two saturating counters keep stats.
`timescale 1ns/1ps
module btb_next_pc #(
    parameter int NrOfEntries = 8,
    parameter int IndexBits   = 3,
    parameter int StatBits    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [31:0]         pc_i,
    input  logic                ex_valid_i,
    input  logic [31:0]         ex_pc_i,
    input  logic                ex_taken_i,
    input  logic [31:0]         ex_target_i,
    input  logic                ex_redirect_i,
    input  logic [31:0]         ex_correct_pc_i,
    output logic [31:0]         next_pc_o,
    output logic                pred_taken_o,
    output logic [31:0]         pred_target_o,
    output logic [StatBits-1:0] branch_count_o,
    output logic [StatBits-1:0] mispredict_count_o
);

    localparam int TagBits = 32 - IndexBits - 2;

    // Table storage, one slot per index.
    logic               valid_q  [NrOfEntries];
    logic [TagBits-1:0] tag_q    [NrOfEntries];
    logic [29:0]        target_q [NrOfEntries];
    logic [1:0]         ctr_q    [NrOfEntries];

    logic [StatBits-1:0] branch_count_q, branch_count_d;
    logic [StatBits-1:0] mispredict_count_q, mispredict_count_d;

    // Fetch-side lookup fields.
    logic [IndexBits-1:0] rd_idx;
    logic [TagBits-1:0]   rd_tag;
    logic                 rd_hit;

    // Training-side fields.
    logic [IndexBits-1:0] ex_idx;
    logic [TagBits-1:0]   ex_tag;
    logic                 ex_hit;
    logic [1:0]           ex_ctr_d;

    // Word-offset bits never take part in indexing, tagging or targets.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pc_i[1:0], ex_pc_i[1:0], ex_target_i[1:0]};

    assign rd_idx = pc_i[IndexBits+1:2];
    assign rd_tag = pc_i[31:IndexBits+2];
    assign ex_idx = ex_pc_i[IndexBits+1:2];
    assign ex_tag = ex_pc_i[31:IndexBits+2];

    // Zero-latency lookup and next-PC selection; reads pre-edge table contents.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        next_pc_o     = pc_i + 32'd4;
        rd_hit        = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        pred_taken_o  = rd_hit && ctr_q[rd_idx][1];
        pred_target_o = rd_hit ? {target_q[rd_idx], 2'b00} : 32'h0;
        if (ex_redirect_i) begin
            next_pc_o = ex_correct_pc_i;
        end else if (pred_taken_o) begin
            next_pc_o = pred_target_o;
        end
    end

    // Training-side hit detection and saturating counter step.
    always_comb begin
        ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        ex_ctr_d = ctr_q[ex_idx];
        if (ex_taken_i) begin
            if (ctr_q[ex_idx] != 2'b11) ex_ctr_d = ctr_q[ex_idx] + 2'd1;
        end else begin
            if (ctr_q[ex_idx] != 2'b00) ex_ctr_d = ctr_q[ex_idx] - 2'd1;
        end
    end

    // Saturating statistics, next-state.
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (ex_valid_i && (branch_count_q != '1)) begin
            branch_count_d = branch_count_q + 1'b1;
        end
        if (ex_redirect_i && (mispredict_count_q != '1)) begin
            mispredict_count_d = mispredict_count_q + 1'b1;
        end
    end

    // Table update from EX resolution: train on hit, allocate on taken miss.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the table is cleared by the async reset because a stale valid bit would
            // otherwise drive a prediction straight out of reset; this costs a reset on every entry.
            for (int i = 0; i < NrOfEntries; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (ex_valid_i) begin
            if (ex_hit) begin
                // NOTE: state uses non-blocking assignment so every read in this edge sees pre-edge values.
                ctr_q[ex_idx] <= ex_ctr_d;
                if (ex_taken_i) target_q[ex_idx] <= ex_target_i[31:2];
            end else if (ex_taken_i) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target_i[31:2];
                ctr_q[ex_idx]    <= 2'b10;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count_o     = branch_count_q;
    assign mispredict_count_o = mispredict_count_q;

endmodule

// File: tb/tb_btb_next_pc.sv
// Bench for btb_next_pc: directed scenarios then random traffic, all checked
// against a table model kept as plain arrays of addresses and integer counters.
`timescale 1ns/1ps
module tb_btb_next_pc;

    localparam int N  = 8;
    localparam int IB = 3;
    localparam int SB = 6;
    localparam int unsigned STAT_MAX = (1 << SB) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   pc, ex_pc, ex_target, ex_correct_pc;
    logic          ex_valid, ex_taken, ex_redirect;
    logic [31:0]   next_pc, pred_target;
    logic          pred_taken;
    logic [SB-1:0] branch_count, mispredict_count;

    int errors = 0;
    int checks = 0;

    btb_next_pc #(.NrOfEntries(N), .IndexBits(IB), .StatBits(SB)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .pc_i               (pc),
        .ex_valid_i         (ex_valid),
        .ex_pc_i            (ex_pc),
        .ex_taken_i         (ex_taken),
        .ex_target_i        (ex_target),
        .ex_redirect_i      (ex_redirect),
        .ex_correct_pc_i    (ex_correct_pc),
        .next_pc_o          (next_pc),
        .pred_taken_o       (pred_taken),
        .pred_target_o      (pred_target),
        .branch_count_o     (branch_count),
        .mispredict_count_o (mispredict_count)
    );

    always #5 clk = ~clk;

    // Reference model: entries hold full word-aligned addresses and integer counters.
    bit          m_valid [N];
    int unsigned m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    int unsigned m_bc, m_mc;

    function automatic int slot(logic [31:0] a);
        return int'((a >> 2) % N);
    endfunction

    function automatic int unsigned tag_of(logic [31:0] a);
        return a >> (IB + 2);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_bc = 0; m_mc = 0;
    endtask

    function automatic bit m_hit(logic [31:0] a);
        return m_valid[slot(a)] && (m_tag[slot(a)] == tag_of(a));
    endfunction

    function automatic bit m_pred_taken();
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target();
        return m_hit(pc) ? m_tgt[slot(pc)] : 32'h0;
    endfunction

    function automatic logic [31:0] m_next_pc();
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (ex_redirect) return ex_correct_pc;
        if (m_pred_taken()) return m_pred_target();
        return seq;
    endfunction

    // Applies the current EX inputs as a clock edge would.
    task automatic m_edge();
        int i;
        if (ex_valid) begin
            i = slot(ex_pc);
            if (m_hit(ex_pc)) begin
                if (ex_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = ex_target & 32'hFFFF_FFFC;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (ex_taken) begin
                m_valid[i] = 1; m_tag[i] = tag_of(ex_pc);
                m_tgt[i] = ex_target & 32'hFFFF_FFFC; m_ctr[i] = 2;
            end
            if (m_bc < STAT_MAX) m_bc++;
        end
        if (ex_redirect && m_mc < STAT_MAX) m_mc++;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".next_pc"},     next_pc,                       m_next_pc());
        check({tag, ".pred_taken"},  {31'h0, pred_taken},           {31'h0, m_pred_taken()});
        check({tag, ".pred_target"}, pred_target,                   m_pred_target());
        check({tag, ".branch_cnt"},  {{(32-SB){1'b0}}, branch_count},     m_bc);
        check({tag, ".mispred_cnt"}, {{(32-SB){1'b0}}, mispredict_count}, m_mc);
    endtask

    task automatic idle_ex();
        ex_valid = 0; ex_pc = 0; ex_taken = 0; ex_target = 0;
        ex_redirect = 0; ex_correct_pc = 0;
    endtask

    // Inputs are set 1ns after an edge; check mid-cycle, step model at the edge.
    task automatic cycle(string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic train(logic [31:0] a, logic t, logic [31:0] tgt);
        ex_valid = 1; ex_pc = a; ex_taken = t; ex_target = tgt;
        cycle("train");
        idle_ex();
    endtask

    initial begin
        rst_n = 0; pc = 32'h0040_0000; idle_ex(); m_reset();
        #2;
        check("rst.next_pc", next_pc, 32'h0040_0004);
        check("rst.pred_taken", {31'h0, pred_taken}, 32'h0);
        ex_redirect = 1; ex_correct_pc = 32'h0000_1230;
        #1;
        check("rst.redirect", next_pc, 32'h0000_1230);
        idle_ex();
        #9 rst_n = 1;                          // release at t=12, away from edges
        @(posedge clk); #1;
        cycle("release");
        check("release.bc", {{(32-SB){1'b0}}, branch_count}, 32'h0);

        // Taken miss allocates with weakly-taken counter.
        train(32'h0040_0010, 1, 32'h0040_0100);
        pc = 32'h0040_0010; #1;
        check("alloc.pred_taken", {31'h0, pred_taken}, 32'h1);
        check("alloc.pred_target", pred_target, 32'h0040_0100);
        check("alloc.next_pc", next_pc, 32'h0040_0100);
        check("alloc.bc", {{(32-SB){1'b0}}, branch_count}, 32'h1);
        pc = 32'h0040_0000;

        // Saturate up, then decay twice.
        repeat (3) train(32'h0040_0010, 1, 32'h0040_0100);
        train(32'h0040_0010, 0, 32'h0);
        pc = 32'h0040_0010; #1;
        check("decay1.pred_taken", {31'h0, pred_taken}, 32'h1);
        train(32'h0040_0010, 0, 32'h0);
        #1;
        check("decay2.pred_taken", {31'h0, pred_taken}, 32'h0);
        check("decay2.next_pc", next_pc, 32'h0040_0014);

        // Alias: same index, different tag.
        pc = 32'h0040_0030; #1;
        check("alias.pred_taken", {31'h0, pred_taken}, 32'h0);
        train(32'h0040_0030, 1, 32'h0040_0300);
        pc = 32'h0040_0010; #1;
        check("replaced.old_miss", {31'h0, pred_taken}, 32'h0);
        pc = 32'h0040_0030;
        cycle("replaced.new_hit");

        // Redirect beats a taken prediction.
        ex_redirect = 1; ex_correct_pc = 32'h0040_0200; #1;
        check("redir.next_pc", next_pc, 32'h0040_0200);
        cycle("redir");
        check("redir.mc", {{(32-SB){1'b0}}, mispredict_count}, 32'h1);
        for (int k = 0; k < 70; k++) cycle("mc_sat");
        check("mc_sat.held", {{(32-SB){1'b0}}, mispredict_count}, STAT_MAX);
        idle_ex();

        // Same-edge lookup/update: old target now, new target next cycle.
        ex_valid = 1; ex_pc = 32'h0040_0030; ex_taken = 1; ex_target = 32'h0040_0400; #1;
        check("same_edge.old", pred_target, 32'h0040_0300);
        cycle("same_edge");
        idle_ex(); #1;
        check("same_edge.new", pred_target, 32'h0040_0400);

        // PC+4 wraps.
        pc = 32'hFFFF_FFFC; #1;
        check("wrap.next_pc", next_pc, 32'h0000_0000);

        // Async reset mid-cycle drops the prediction immediately.
        pc = 32'h0040_0030; #1;
        check("pre_rst.pred_taken", {31'h0, pred_taken}, 32'h1);
        rst_n = 0; m_reset(); #1;
        check("async_rst.pred_taken", {31'h0, pred_taken}, 32'h0);
        check("async_rst.next_pc", next_pc, 32'h0040_0034);
        check("async_rst.bc", {{(32-SB){1'b0}}, branch_count}, 32'h0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        train(32'h0040_0030, 1, 32'h0040_0500);
        cycle("post_rst");

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            pc            = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                          : 32'h0040_0000 + ($urandom_range(0, 31) << 2);
            ex_valid      = $urandom_range(0, 1);
            ex_pc         = 32'h0040_0000 + ($urandom_range(0, 31) << 2);
            ex_taken      = $urandom_range(0, 1);
            ex_target     = $urandom;
            ex_redirect   = ($urandom_range(0, 7) == 0);
            ex_correct_pc = $urandom;
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btb_next_pc.md
Name: btb_next_pc

Overview:
Next-PC generation stage directly upstream of the PC register in the redirection pipeline with BTB. It holds a direct-mapped branch target buffer with 2-bit saturating direction counters. Each cycle it looks up the current fetch PC and drives the PC register's D input with one of three values: the redirect target, the predicted target, or PC+4. EX-stage branch resolution trains the table, and the block keeps saturating statistics counters.

Parameters:
NrOfEntries, 8, BTB entries; power of two, 2..64
IndexBits, 3, log2(NrOfEntries); index = pc[IndexBits+1:2]
StatBits, 16, width of the statistics counters

Ports:
Clock  in  1  single clock; all state updates on rising edge
Reset  in  1  asynchronous, active-low; clears all state
pc  in  32  current fetch PC, from the PC register Q
ex_valid  in  1  EX stage holds a resolved control-transfer instruction this cycle
ex_pc  in  32  PC of the resolved branch
ex_taken  in  1  actual branch outcome
ex_target  in  32  actual taken target
ex_redirect  in  1  EX detected a misprediction; fetch must restart at ex_correct_pc
ex_correct_pc  in  32  restart address
next_pc  out  32  D input of the PC register
pred_taken  out  1  prediction for pc; carried down the pipe for EX compare
pred_target  out  32  predicted target for pc; carried down the pipe
branch_count  out  StatBits  resolved branches since reset
mispredict_count  out  StatBits  redirects since reset

Behaviour:
- Entry state: valid(1), tag = pc[31:IndexBits+2], target[31:2], ctr(2). Targets are word-aligned; target[1:0] is reconstructed as 2'b00.
- Reset low (asynchronous): all valid=0, all ctr=2'b01, all tag/target=0, branch_count=0, mispredict_count=0. Outputs while in reset: pred_taken=0, pred_target=0, and next_pc = ex_redirect ? ex_correct_pc : pc+4.
- Lookup is combinational, with zero latency:
  - hit = valid[idx(pc)] & (tag == pc tag).
  - pred_taken = hit & ctr[1].
  - pred_target = hit ? {target,2'b00} : 32'h0.
- next_pc priority:
  1. ex_redirect=1 -> ex_correct_pc.
  2. pred_taken=1 -> pred_target.
  3. Otherwise -> pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- Training happens at the rising edge when ex_valid=1, using ex_pc index and tag:
  - Tag-match hit: ctr saturating +1 if ex_taken, -1 if not; ctr stays at 2'b11 and 2'b00. If ex_taken, target <= ex_target[31:2].
  - Miss with ex_taken=1: allocate or replace the entry. valid=1, tag=ex_pc tag, target=ex_target[31:2], ctr=2'b10 (weakly taken).
  - Miss with ex_taken=0: the table is unchanged.
- Simultaneous lookup and update of the same index: the lookup sees the pre-edge contents. There is no write-to-read bypass; the new contents are visible the next cycle.
- Stats:
  - branch_count +1 per cycle with ex_valid=1.
  - mispredict_count +1 per cycle with ex_redirect=1, independent of ex_valid.
  - Both counters saturate at all-ones and do not wrap.
- ex_redirect without ex_valid: next_pc is still redirected; the table is untouched.
- A reset asserted mid-operation clears the table within the same cycle (asynchronous). Training resumes on the first rising edge after Reset returns high.
- There are no X outputs: every path is defined from the reset state.

Test Plan:
- Reset release, pc=0x00400000, no EX activity -> next_pc=0x00400004, pred_taken=0, both counts 0.
- Train miss-allocate: ex_valid=1, ex_pc=0x00400010, ex_taken=1, ex_target=0x00400100 for one edge. Then pc=0x00400010 -> pred_taken=1, pred_target=0x00400100, next_pc=0x00400100, branch_count=1.
- Counter saturation/decay on that entry: three taken updates (ctr=11), then one not-taken -> still predicts taken (ctr=10). A second not-taken -> pred_taken=0 and next_pc=0x00400014.
- Alias/tag miss: pc=0x00400030 (same index, different tag) -> pred_taken=0. A taken update at 0x00400030 replaces the entry, and 0x00400010 then misses.
- Redirect priority: pc is a predicted-taken hit and ex_redirect=1 with ex_correct_pc=0x00400200 -> next_pc=0x00400200 and mispredict_count increments. With the counter forced near saturation, 2^StatBits-1 is held.
- Same-edge lookup/update plus wrap: update the idx of pc with a new target and check the old target is output in that cycle and the new one next cycle. pc=0xFFFFFFFC with a miss -> next_pc=0x00000000. Async Reset pulse mid-run -> pred_taken drops to 0 immediately.
